// File: rtl/ysyx_23060072_dmem_slave_pkg.sv
// Shared constants for the data-memory responder: FSM encodings, LFSR seed/step, defaults.
// The randomised-latency option is YSYX_23060072_DMEM_RAND_LAT_EN (see the top module).
package ysyx_23060072_dmem_slave_pkg;

  typedef logic [1:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE = 2'd0;
  localparam dmem_state_t ST_WAIT = 2'd1;
  localparam dmem_state_t ST_RESP = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam int DEFAULT_DEPTH_LOG2 = 10;
  localparam int DEFAULT_LAT        = 1;

  // Fibonacci step, taps 8,6,5,4 (1-based), shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/ysyx_23060072_dmem_slave_if.sv
// LSU <-> data-memory request/response bundle; master is the LSU, slave the memory.
interface ysyx_23060072_dmem_slave_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ysyx_23060072_lfsr8.sv
// 8-bit Fibonacci LFSR with advance enable; synchronous active-low reset to the seed.
module ysyx_23060072_lfsr8
  import ysyx_23060072_dmem_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/ysyx_23060072_dmem_slave.sv
// Single-outstanding word memory responder with byte-strobed stores and fixed/random latency.
// Define YSYX_23060072_DMEM_RAND_LAT_EN to add 0..3 cycles of LFSR-driven extra latency.
module ysyx_23060072_dmem_slave
  import ysyx_23060072_dmem_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LAT        = DEFAULT_LAT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_23060072_dmem_slave_if.slave    bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  dmem_state_t           state_reg, state_next;
  logic [4:0]            cnt_reg, cnt_next;
  logic                  we_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  accept;
  logic                  enter_resp;
  logic                  rd_is_load;
  logic [4:0]            lat_m1;

  assign req_idx = bus.req_addr[DEPTH_LOG2+1:2];
  // No acceptance (and hence no store) can happen on a reset edge.
  assign accept  = rst_n && bus.req_valid && (state_reg == ST_IDLE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0]};

`ifdef YSYX_23060072_DMEM_RAND_LAT_EN
  logic [7:0] lfsr_value;
  logic       unused_lfsr_bits;

  ysyx_23060072_lfsr8 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .value   (lfsr_value)
  );

  assign lat_m1           = 5'(LAT) + {3'b000, lfsr_value[1:0]} - 5'd1;
  assign unused_lfsr_bits = ^lfsr_value[7:2];
`else
  assign lat_m1 = 5'(LAT - 1);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          cnt_next   = lat_m1;
          state_next = (lat_m1 == 5'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter holds L-1-k after k WAIT edges; RESP is entered as it hits zero.
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg <= 5'd1) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg  <= bus.req_we;
        idx_reg <= req_idx;
      end
    end
  end

  // With L=1 the read happens on the acceptance edge, so take the live request fields.
  assign enter_resp = rst_n && (state_next == ST_RESP) && (state_reg != ST_RESP);
  assign rd_idx     = (state_reg == ST_IDLE) ? req_idx : idx_reg;
  assign rd_is_load = (state_reg == ST_IDLE) ? !bus.req_we : !we_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (accept && bus.req_we && bus.req_wstrb[gi]) begin
          lane_mem[req_idx] <= bus.req_wdata[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_byte_reg <= 8'h00;
        end else if (enter_resp) begin
          rd_byte_reg <= rd_is_load ? lane_mem[rd_idx] : 8'h00;
        end
      end
    end
  endgenerate

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.rsp_rdata = {g_lane[3].rd_byte_reg, g_lane[2].rd_byte_reg,
                          g_lane[1].rd_byte_reg, g_lane[0].rd_byte_reg};

endmodule
